pdp_trace_arbiter: RTL and testbench

Collects memory-access trace events from the three access sources of the PDP-11 simulator core (data read, data write, instruction fetch) and serializes them into a single 18-bit trace record stream for the trace-file writer. Each record is {2-bit access type, 16-bit address}, which matches the format the writer prints as two octal fields. A round-robin arbiter grants one source per cycle into a small show-ahead FIFO. A valid/ready handshake drains the FIFO to the writer, so back-to-back identical records are never merged or lost.

---
 rtl/pdp_trace_arbiter.sv | 59 +++++
 tb/tb_pdp_trace_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pdp_trace_arbiter.sv
// pdp_trace_arbiter: round-robin merge of read/write/fetch trace events into
// an 18-bit {type, address} record stream through a show-ahead FIFO.
module pdp_trace_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 req,
    input  logic [15:0]                addr0,
    input  logic [15:0]                addr1,
    input  logic [15:0]                addr2,
    output logic [2:0]                 gnt,
    output logic                       trace_valid,
    output logic [17:0]                trace_data,
    input  logic                       trace_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [31:0]                rec_total
);
    localparam int AW = $clog2(DEPTH);
    logic [17:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [1:0]    last, c0, c1, c2, win;
    logic [15:0]   addr;
    logic          push, pop;
    always_comb begin
        c0 = (last == 2'd2) ? 2'd0 : last + 2'd1;
        c1 = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
        c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        win = req[c0] ? c0 : req[c1] ? c1 : c2;
        addr = (win == 2'd0) ? addr0 : (win == 2'd1) ? addr1 : addr2;
        // no full-bypass: a simultaneous pop does not open a slot this cycle
        push = !reset && (req != 3'b000) && (count < (AW + 1)'(DEPTH));
        gnt = push ? (3'b001 << win) : 3'b000;
        trace_valid = (count != '0);
        pop = trace_valid && trace_ready;
        trace_data = mem[rd_ptr];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            last <= 2'd2;
            count <= '0;
            rec_total <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {win, addr};
                wr_ptr <= wr_ptr + 1'b1;
                last <= win;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                rec_total <= rec_total + 32'd1;
            end
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end
endmodule

// File: tb/tb_pdp_trace_arbiter.sv
// tb_pdp_trace_arbiter: directed vectors with hand-computed expectations
// for arbitration, FIFO ordering, back-pressure and asynchronous reset.
module tb_pdp_trace_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [15:0] addr0, addr1, addr2;
    logic [2:0]  gnt;
    logic        trace_valid;
    logic [17:0] trace_data;
    logic        trace_ready;
    logic [2:0]  count;
    logic [31:0] rec_total;
    int checks = 0;
    int errors = 0;

    pdp_trace_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .req(req), .addr0(addr0), .addr1(addr1),
        .addr2(addr2), .gnt(gnt), .trace_valid(trace_valid),
        .trace_data(trace_data), .trace_ready(trace_ready), .count(count),
        .rec_total(rec_total)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; req = 3'b111; trace_ready = 1'b0;
        addr0 = 16'd1; addr1 = 16'd2; addr2 = 16'd3;
        #1;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(trace_valid), 0);
        check("rst_data", 32'(trace_data), 0);
        check("rst_total", rec_total, 0);
        req = 3'b000;
        @(negedge clk) reset = 1'b0;
        tick();

        // single read
        trace_ready = 1'b1; req = 3'b001; addr0 = 16'o001000;
        #1 check("rd_gnt", 32'(gnt), 32'b001);
        tick();
        req = 3'b000;
        check("rd_valid", 32'(trace_valid), 1);
        check("rd_data", 32'(trace_data), 32'o0001000);
        tick();
        check("rd_valid_after", 32'(trace_valid), 0);
        check("rd_total", rec_total, 1);

        // round robin, last granted is read
        req = 3'b111; addr0 = 16'd1; addr1 = 16'd2; addr2 = 16'd3;
        for (int k = 0; k < 6; k++) begin
            #1 check("rr_gnt", 32'(gnt), 32'(1) << ((k + 1) % 3));
            tick();
            check("rr_type", 32'(trace_data[17:16]), 32'((k + 1) % 3));
            check("rr_count", 32'(count), 1);
        end
        req = 3'b000;
        tick();
        check("rr_total", rec_total, 7);
        check("rr_empty", 32'(count), 0);

        // full FIFO with fetch only
        trace_ready = 1'b0; req = 3'b100;
        for (int k = 0; k < 4; k++) begin
            addr2 = 16'o000300 + 16'(k);
            #1 check("full_gnt", 32'(gnt), 32'b100);
            tick();
        end
        addr2 = 16'o000304;
        check("full_count", 32'(count), 4);
        check("full_gnt_blocked", 32'(gnt), 0);
        trace_ready = 1'b1;
        #1 check("full_no_bypass", 32'(gnt), 0);
        check("full_head", 32'(trace_data), 32'({2'd2, 16'o000300}));
        tick();
        trace_ready = 1'b0;
        check("full_pop_count", 32'(count), 3);
        check("full_pop_total", rec_total, 8);
        #1 check("full_regrant", 32'(gnt), 32'b100);
        tick();
        req = 3'b000;
        check("full_refill", 32'(count), 4);
        trace_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("full_order", 32'(trace_data), 32'({2'd2, 16'o000300 + 16'(k)}));
            tick();
        end
        check("full_drained", 32'(count), 0);
        check("full_total", rec_total, 12);

        // identical back-to-back records
        req = 3'b100; addr2 = 16'o000200;
        for (int k = 0; k < 3; k++) begin
            #1 check("same_gnt", 32'(gnt), 32'b100);
            tick();
            check("same_data", 32'(trace_data), 32'({2'd2, 16'o000200}));
        end
        req = 3'b000;
        tick();
        check("same_total", rec_total, 15);
        check("same_empty", 32'(count), 0);

        // simultaneous push and pop at count 2
        trace_ready = 1'b0; req = 3'b010; addr1 = 16'o000400;
        tick();
        addr1 = 16'o000401;
        tick();
        check("pp_fill", 32'(count), 2);
        trace_ready = 1'b1; addr1 = 16'o000402;
        #1 check("pp_gnt", 32'(gnt), 32'b010);
        tick();
        check("pp_count1", 32'(count), 2);
        check("pp_head1", 32'(trace_data), 32'({2'd1, 16'o000401}));
        addr1 = 16'o000403;
        tick();
        check("pp_count2", 32'(count), 2);
        check("pp_head2", 32'(trace_data), 32'({2'd1, 16'o000402}));
        check("pp_total", rec_total, 17);

        // asynchronous reset between edges with count 3
        trace_ready = 1'b0; addr1 = 16'o000404;
        tick();
        check("ar_fill", 32'(count), 3);
        req = 3'b111; addr0 = 16'o000777;
        #2 reset = 1'b1;
        #1;
        check("ar_count", 32'(count), 0);
        check("ar_valid", 32'(trace_valid), 0);
        check("ar_data", 32'(trace_data), 0);
        check("ar_total", rec_total, 0);
        check("ar_gnt", 32'(gnt), 0);
        @(negedge clk) reset = 1'b0;
        #1 check("ar_first_gnt", 32'(gnt), 32'b001);
        tick();
        req = 3'b000;
        check("ar_first_data", 32'(trace_data), 32'({2'd0, 16'o000777}));
        check("ar_first_count", 32'(count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
